// File: rtl/fw_config_tx.sv
// fw_config_tx: configuration bus initiator.
// Commands (target ID + payload length) are checked, held until their payload
// bytes are queued and tracing is paused, then sent as one contiguous frame:
// a header cycle, the payload cycles, and one idle gap cycle.
// Bus outputs are registered and lag the state register by one cycle.

module fw_config_tx #(
   parameter int         MAX_PAYLOAD = 16,
   parameter int         FIFO_DEPTH  = 16,
   parameter logic [7:0] IDLE_ID     = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tracing,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_target,
   input  logic [7:0] cmd_len,
   input  logic       data_valid,
   output logic       data_ready,
   input  logic [7:0] data_in,
   output logic [7:0] configId,
   output logic [7:0] configData,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int              AW         = $clog2(FIFO_DEPTH);
   localparam int              CW         = AW + 1;
   localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);
   localparam logic [7:0]      MAX_LEN    = 8'(MAX_PAYLOAD);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CHECK   = 3'd1,
      S_WAIT    = 3'd2,
      S_HEADER  = 3'd3,
      S_PAYLOAD = 3'd4,
      S_GAP     = 3'd5
   } state_t;

   state_t          state_r;
   logic [7:0]      tgt_r;
   logic [7:0]      len_r;
   logic [7:0]      rem_r;
   logic            cmd_ready_r;
   logic [7:0]      cfg_id_r;
   logic [7:0]      cfg_data_r;
   logic            done_r;
   logic            err_r;
   logic            rej_r;

   logic [7:0]      mem_r [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;

   logic            push_s;
   logic            pop_s;
   logic            accept_s;
   logic            bad_cmd_s;
   logic            data_short_s;

   // Handshake and frame-start decode from the registered state
   always_comb begin
      push_s       = data_valid && (count_r != FULL_COUNT);
      pop_s        = (state_r == S_PAYLOAD);
      accept_s     = cmd_valid && cmd_ready_r;
      bad_cmd_s    = (len_r > MAX_LEN) || (tgt_r == IDLE_ID);
      data_short_s = (16'(count_r) < 16'(len_r));
   end

   // Payload byte storage; no reset needed since count gates every read
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // Byte FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1'b1);
            2'b01:   count_r <= count_r - CW'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Frame sequencer with registered bus, handshake and pulse outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= S_IDLE;
         tgt_r       <= 8'h00;
         len_r       <= 8'h00;
         rem_r       <= 8'h00;
         cmd_ready_r <= 1'b1;
         cfg_id_r    <= IDLE_ID;
         cfg_data_r  <= 8'h00;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         rej_r       <= 1'b0;
      end else begin
         cfg_id_r    <= IDLE_ID;
         cfg_data_r  <= 8'h00;
         done_r      <= 1'b0;
         cmd_ready_r <= 1'b0;
         rej_r       <= 1'b0;
         // err trails the rejecting CHECK edge by one cycle, like the bus
         err_r       <= rej_r;
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  tgt_r   <= cmd_target;
                  len_r   <= cmd_len;
                  state_r <= S_CHECK;
               end else begin
                  cmd_ready_r <= 1'b1;
               end
            end
            S_CHECK: begin
               if (bad_cmd_s) begin
                  rej_r   <= 1'b1;
                  state_r <= S_IDLE;
               end else begin
                  state_r <= S_WAIT;
               end
            end
            S_WAIT: begin
               // tracing is only sampled here; a started frame is never aborted
               if (!data_short_s && !tracing) begin
                  state_r <= S_HEADER;
               end else begin
                  state_r <= S_WAIT;
               end
            end
            S_HEADER: begin
               cfg_id_r   <= tgt_r;
               cfg_data_r <= len_r;
               rem_r      <= len_r;
               if (len_r != 8'd0) begin
                  state_r <= S_PAYLOAD;
               end else begin
                  state_r <= S_GAP;
               end
            end
            S_PAYLOAD: begin
               cfg_id_r   <= tgt_r;
               cfg_data_r <= mem_r[rd_ptr_r];
               rem_r      <= rem_r - 8'd1;
               if (rem_r == 8'd1) begin
                  state_r <= S_GAP;
               end else begin
                  state_r <= S_PAYLOAD;
               end
            end
            S_GAP: begin
               done_r  <= 1'b1;
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_r;
   assign data_ready = (count_r != FULL_COUNT);
   assign configId   = cfg_id_r;
   assign configData = cfg_data_r;
   assign busy       = (state_r != S_IDLE);
   assign done       = done_r;
   assign err        = err_r;

endmodule

// File: tb/tb_fw_config_tx.sv
// Self-checking bench for fw_config_tx: cycle tables for the exact frame and
// reject timing, hand sequences for tracing gate, starvation, FIFO full/wrap
// and mid-frame reset, then random commands against a queue-based model.

module tb_fw_config_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       tracing;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_target;
   logic [7:0] cmd_len;
   logic       data_valid;
   logic       data_ready;
   logic [7:0] data_in;
   logic [7:0] configId;
   logic [7:0] configData;
   logic       busy;
   logic       done;
   logic       err;

   fw_config_tx dut (
      .clk        (clk),
      .reset      (reset),
      .tracing    (tracing),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_target (cmd_target),
      .cmd_len    (cmd_len),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .data_in    (data_in),
      .configId   (configId),
      .configData (configData),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] id;
      logic [7:0] dat;
      logic       done;
      logic       err;
      logic       busy;
      logic       crdy;
      logic       drdy;
   } vec_t;

   int          checks_total  = 0;
   int          checks_passed = 0;
   int          done_cnt      = 0;
   int          err_cnt       = 0;
   logic [15:0] bus_q[$];
   logic [7:0]  model_q[$];
   logic [15:0] exp_q[$];

   vec_t basic_tbl[9];
   vec_t rej_tbl[4];
   vec_t rst_v;

   // Bus monitor: records every non-idle bus cycle and counts pulses
   always @(negedge clk) begin
      if (configId != 8'hFF) bus_q.push_back({configId, configData});
      if (done) done_cnt++;
      if (err) err_cnt++;
   end

   function automatic vec_t mk(input logic [7:0] id, input logic [7:0] dat, input logic dn,
                               input logic er, input logic bs, input logic cr, input logic dr);
      vec_t v;
      v.id = id; v.dat = dat; v.done = dn; v.err = er; v.busy = bs; v.crdy = cr; v.drdy = dr;
      return v;
   endfunction

   task automatic check(input bit cond, input string name, input string detail);
      checks_total++;
      if (cond) checks_passed++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   task automatic check_vec(input string name, input vec_t e);
      bit ok;
      ok = (configId == e.id) && (configData == e.dat) && (done == e.done) && (err == e.err) &&
           (busy == e.busy) && (cmd_ready == e.crdy) && (data_ready == e.drdy);
      check(ok, name, $sformatf("got id=%h dat=%h done=%b err=%b busy=%b crdy=%b drdy=%b, want id=%h dat=%h done=%b err=%b busy=%b crdy=%b drdy=%b",
            configId, configData, done, err, busy, cmd_ready, data_ready,
            e.id, e.dat, e.done, e.err, e.busy, e.crdy, e.drdy));
   endtask

   // Offer one byte for a cycle; the model keeps it only if it had room
   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = b;
      if (model_q.size() < 16) model_q.push_back(b);
      @(posedge clk);
      #1 data_valid = 1'b0;
   endtask

   // Present a command once the DUT is ready; returns just after the accept edge
   task automatic send_cmd(input logic [7:0] t, input logic [7:0] l, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check(1'b0, "cmd_accept", $sformatf("cmd_ready still %b after 200 cycles, want 1", cmd_ready));
         return;
      end
      cmd_valid  = 1'b1;
      cmd_target = t;
      cmd_len    = l;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_end(input int d0, input int e0, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         if (done_cnt != d0 || err_cnt != e0) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) check(1'b0, name, "no done/err within 400 cycles, want one");
   endtask

   // Expected frame: header, then len bytes in FIFO order taken from the model
   task automatic build_frame(input logic [7:0] t, input logic [7:0] l);
      exp_q.delete();
      exp_q.push_back({t, l});
      for (int i = 0; i < int'(l); i++) exp_q.push_back({t, model_q.pop_front()});
   endtask

   task automatic cmp_frame(input string name, input int b0);
      bit    ok;
      string d;
      ok = 1'b1;
      d  = "";
      if (bus_q.size() - b0 != exp_q.size()) begin
         ok = 1'b0;
         d  = $sformatf("got %0d bus cycles, want %0d", bus_q.size() - b0, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            if (bus_q[b0 + i] != exp_q[i]) begin
               ok = 1'b0;
               d  = $sformatf("cycle %0d got %h want %h", i, bus_q[b0 + i], exp_q[i]);
               break;
            end
         end
      end
      check(ok, name, d);
   endtask

   // One full command against the model; hold>0 keeps tracing high that long
   task automatic run_cmd(input logic [7:0] t, input logic [7:0] l, input int hold);
      int b0, d0, e0;
      bit ok, bad;
      bad = (l > 8'd16) || (t == 8'hFF);
      if (!bad && hold > 0) tracing = 1'b1;
      b0 = bus_q.size(); d0 = done_cnt; e0 = err_cnt;
      send_cmd(t, l, ok);
      if (!ok) begin
         tracing = 1'b0;
         return;
      end
      if (!bad && hold > 0) begin
         repeat (hold) @(posedge clk);
         #2;
         check(bus_q.size() == b0, "trace_hold",
               $sformatf("got %0d bus cycles while tracing, want 0", bus_q.size() - b0));
         tracing = 1'b0;
      end
      wait_end(d0, e0, $sformatf("end_t%h_l%0d", t, l));
      if (bad) begin
         check((err_cnt == e0 + 1) && (done_cnt == d0) && (bus_q.size() == b0),
               $sformatf("reject_t%h_l%0d", t, l),
               $sformatf("got err=%0d done=%0d bus=%0d, want err=1 done=0 bus=0",
                         err_cnt - e0, done_cnt - d0, bus_q.size() - b0));
      end else begin
         build_frame(t, l);
         cmp_frame($sformatf("frame_t%h_l%0d", t, l), b0);
         check((done_cnt == d0 + 1) && (err_cnt == e0), $sformatf("done_t%h_l%0d", t, l),
               $sformatf("got done=%0d err=%0d, want done=1 err=0", done_cnt - d0, err_cnt - e0));
      end
   endtask

   initial begin
      int          b0, d0, e0, nonidle;
      bit          ok;
      logic [7:0]  t, l;
      int          hold;

      reset = 1'b1; tracing = 1'b0; cmd_valid = 1'b0; cmd_target = 8'h00;
      cmd_len = 8'h00; data_valid = 1'b0; data_in = 8'h00;

      rst_v = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      // target 02 len 3, bytes 11 22 33; row k sampled after accept edge + k
      basic_tbl[0] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      basic_tbl[1] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      basic_tbl[2] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      basic_tbl[3] = mk(8'h02, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      basic_tbl[4] = mk(8'h02, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      basic_tbl[5] = mk(8'h02, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      basic_tbl[6] = mk(8'h02, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      basic_tbl[7] = mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      basic_tbl[8] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      // target 09 len 17 rejected
      rej_tbl[0] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      rej_tbl[1] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rej_tbl[2] = mk(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      rej_tbl[3] = mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_vec("reset_state", rst_v);

      // Basic frame, cycle by cycle
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
      send_cmd(8'h02, 8'h03, ok);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check_vec($sformatf("basic_k%0d", k), basic_tbl[k]);
      end
      for (int k = 0; k < 3; k++) void'(model_q.pop_front());

      // Reject timing, then len=0 and target=IDLE cases; 5A proves no pop
      send_cmd(8'h09, 8'd17, ok);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_vec($sformatf("reject_k%0d", k), rej_tbl[k]);
      end
      push_byte(8'h5A);
      run_cmd(8'h07, 8'd0, 0);
      run_cmd(8'hFF, 8'd0, 0);
      run_cmd(8'h08, 8'd1, 0);

      // Tracing gate
      tracing = 1'b1;
      push_byte(8'hAA);
      send_cmd(8'h05, 8'd1, ok);
      nonidle = 0;
      repeat (20) begin
         @(negedge clk);
         if (configId != 8'hFF || busy != 1'b1) nonidle++;
      end
      check(nonidle == 0, "trace_gate", $sformatf("got %0d non-idle/not-busy cycles, want 0", nonidle));
      tracing = 1'b0;
      @(negedge clk);
      check_vec("trace_edge1", mk(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      @(negedge clk);
      check_vec("trace_header", mk(8'h05, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      tracing = 1'b1;
      @(negedge clk);
      check_vec("trace_payload", mk(8'h05, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
      @(negedge clk);
      check_vec("trace_gap", mk(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      tracing = 1'b0;
      void'(model_q.pop_front());

      // Data starvation
      push_byte(8'hC1); push_byte(8'hC2);
      b0 = bus_q.size(); d0 = done_cnt; e0 = err_cnt;
      send_cmd(8'h03, 8'd4, ok);
      repeat (10) @(posedge clk);
      #2;
      check((bus_q.size() == b0) && busy, "starve_wait",
            $sformatf("got bus=%0d busy=%b, want bus=0 busy=1", bus_q.size() - b0, busy));
      push_byte(8'hC3); push_byte(8'hC4);
      wait_end(d0, e0, "starve_end");
      build_frame(8'h03, 8'd4);
      cmp_frame("starve_frame", b0);

      // FIFO full, ignored 17th byte, wrap-around
      for (int i = 0; i < 16; i++) push_byte(8'($urandom));
      @(negedge clk);
      check(data_ready == (model_q.size() < 16), "fifo_full",
            $sformatf("got data_ready=%b, want %b", data_ready, model_q.size() < 16));
      push_byte(8'hEE);
      run_cmd(8'h21, 8'd8, 0);
      run_cmd(8'h22, 8'd8, 0);
      for (int i = 0; i < 16; i++) push_byte(8'($urandom));
      @(negedge clk);
      check(data_ready == (model_q.size() < 16), "fifo_full2",
            $sformatf("got data_ready=%b, want %b", data_ready, model_q.size() < 16));
      run_cmd(8'h23, 8'd16, 0);

      // Reset in the middle of payload byte 2 of a len=6 frame
      for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
      b0 = bus_q.size();
      send_cmd(8'h0A, 8'd6, ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (bus_q.size() >= b0 + 3) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check(1'b0, "midframe_wait", "payload byte 1 never seen within 100 cycles");
      #2 reset = 1'b1;
      #1;
      check((configId == 8'hFF) && (configData == 8'h00), "reset_async",
            $sformatf("got id=%h dat=%h, want id=ff dat=00", configId, configData));
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_q.delete();
      @(negedge clk);
      check_vec("reset_release", rst_v);
      push_byte(8'h5C);
      run_cmd(8'h01, 8'd1, 0);

      // Random commands against the queue model
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < int'($urandom_range(0, 4)); i++) push_byte(8'($urandom));
         case ($urandom_range(0, 9))
            0: begin t = 8'hFF; l = 8'($urandom_range(0, 20)); end
            1: begin t = 8'($urandom_range(0, 254)); l = 8'($urandom_range(17, 255)); end
            default: begin t = 8'($urandom_range(0, 254)); l = 8'($urandom_range(0, 16)); end
         endcase
         if (t != 8'hFF && l <= 8'd16) begin
            while (model_q.size() < int'(l)) push_byte(8'($urandom));
         end
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
         run_cmd(t, l, hold);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
